// File: rtl/vx_cache_bank_flush_walker_if.sv
// Handshake bundle between a cache bank and its flush walker: controller pulses,
// the flush-op issue channel, and bank status (retire pulses, memory queue empty).
interface vx_cache_bank_flush_walker_if #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic             flush_begin;
  logic             flush_end;
  logic             flush_busy;
  logic             fop_valid;
  logic [SET_W-1:0] fop_set;
  logic [WAY_W-1:0] fop_way;
  logic             fop_inval;
  logic             fop_ready;
  logic             fop_done;
  logic             mreq_empty;

  // Walker side
  modport master (
    input  flush_begin,
    input  fop_ready,
    input  fop_done,
    input  mreq_empty,
    output flush_end,
    output flush_busy,
    output fop_valid,
    output fop_set,
    output fop_way,
    output fop_inval
  );

  // Bank / controller side
  modport slave (
    output flush_begin,
    output fop_ready,
    output fop_done,
    output mreq_empty,
    input  flush_end,
    input  flush_busy,
    input  fop_valid,
    input  fop_set,
    input  fop_way,
    input  fop_inval
  );
endinterface

// File: rtl/vx_cache_bank_flush_walker.sv
// Per-bank flush walker: issues one flush op per (set, way) line, then waits for retirement and
// an empty memory-request queue before pulsing flush_end. VX_FLUSH_WALKER_INVAL_EN makes every op invalidate.
module vx_cache_bank_flush_walker #(
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int MAX_PENDING = 4
) (
  input  logic clk,
  input  logic reset,
  vx_cache_bank_flush_walker_if.master bus
);
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam int WAY_W    = (NUM_WAYS > 1) ? WAY_BITS : 1;
  localparam int IDX_W    = SET_W + WAY_BITS;
  localparam int PEND_W   = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
`ifdef VX_FLUSH_WALKER_INVAL_EN
  localparam logic INVAL_EN = 1'b1;
`else
  localparam logic INVAL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [PEND_W-1:0]   pending_reg, pending_next;
  logic [SET_W-1:0]    set_idx;
  logic [WAY_W-1:0]    way_idx;
  logic                op_valid;
  logic                fire;
  logic                walk_last;

  // Set occupies the low bits so the walk is set-inner, way-outer.
  assign set_idx   = idx_reg[SET_W-1:0];
  assign walk_last = &idx_reg;
  assign fire      = op_valid & bus.fop_ready;

  generate
    if (NUM_WAYS > 1) begin : g_way
      assign way_idx = idx_reg[IDX_W-1:SET_W];
    end else begin : g_no_way
      assign way_idx = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;

    // A retire with nothing outstanding is dropped rather than wrapping the count.
    if (fire && !bus.fop_done) begin
      pending_next = pending_reg + PEND_W'(1);
    end else if (!fire && bus.fop_done && (pending_reg != '0)) begin
      pending_next = pending_reg - PEND_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.flush_begin) begin
          state_next = ST_WALK;
          idx_next   = '0;
        end
      end
      ST_WALK: begin
        if (fire) begin
          idx_next = idx_reg + IDX_W'(1);
          if (walk_last) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Judged on the settled count, so the final retirement lands before completion.
        if ((pending_reg == '0) && bus.mreq_empty) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    op_valid       = 1'b0;
    bus.flush_busy = 1'b0;
    bus.flush_end  = 1'b0;
    if (reset) begin
      op_valid       = (state_reg == ST_WALK) && (pending_reg != PEND_MAX);
      bus.flush_busy = (state_reg != ST_IDLE);
      bus.flush_end  = (state_reg == ST_DONE);
    end
    bus.fop_valid = op_valid;
    bus.fop_set   = op_valid ? set_idx : '0;
    bus.fop_way   = op_valid ? way_idx : '0;
    bus.fop_inval = op_valid & INVAL_EN;
  end

  always @(posedge clk) begin
    if (reset) begin
      assert (!(bus.flush_begin && (state_reg != ST_IDLE)))
        else $warning("flush_begin ignored while walker busy");
      assert (!(bus.fop_done && (pending_reg == '0)))
        else $error("fop_done received with no flush op outstanding");
    end
  end
endmodule

// File: tb/tb_vx_cache_bank_flush_walker.sv
// Directed bench for vx_cache_bank_flush_walker (4 sets, 2 ways, 2 pending): a counter-level
// model of the flush sequence is compared against the DUT every cycle, plus literal timing checks.
module tb_vx_cache_bank_flush_walker;
  localparam int NUM_SETS = 4;
  localparam int NUM_WAYS = 2;
  localparam int MAXP     = 2;
  localparam int N        = NUM_SETS * NUM_WAYS;
`ifdef VX_FLUSH_WALKER_INVAL_EN
  localparam int INV = 1;
`else
  localparam int INV = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  vx_cache_bank_flush_walker_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) bus ();

  vx_cache_bank_flush_walker #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit hold_done = 1'b0;
  int fire_total = 0, end_total = 0, busy_total = 0, inval_total = 0;
  int obs_pend = 0, obs_pend_max = 0;
  int fire_cyc_q[$], fire_set_q[$], fire_way_q[$], end_cyc_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  // Bank pipeline stand-in: each accepted op retires one cycle later unless held back.
  initial begin
    int owed;
    owed = 0;
    bus.fop_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.fop_valid && bus.fop_ready) owed++;
      @(posedge clk);
      #2;
      if (!reset) owed = 0;
      if (owed > 0 && !hold_done) begin
        bus.fop_done = 1'b1;
        owed--;
      end else begin
        bus.fop_done = 1'b0;
      end
    end
  end

  // Model: a flush is "busy" from the cycle after an accepted request; ops are numbered 0..N-1
  // (set = k % NUM_SETS, way = k / NUM_SETS); completion is signalled the cycle after the
  // first post-walk cycle that starts with nothing outstanding and an empty memory queue.
  initial begin
    bit m_busy;
    int m_fires, m_pend, m_cd;
    int exp_valid, exp_busy, exp_end, f, d;
    m_busy = 0; m_fires = 0; m_pend = 0; m_cd = 0;
    forever begin
      @(negedge clk);
      exp_valid = (reset && m_busy && m_cd == 0 && m_fires < N && m_pend < MAXP) ? 1 : 0;
      exp_busy  = (reset && m_busy) ? 1 : 0;
      exp_end   = (reset && m_busy && m_cd == 1) ? 1 : 0;
      check("fop_valid", int'(bus.fop_valid), exp_valid);
      check("flush_busy", int'(bus.flush_busy), exp_busy);
      check("flush_end", int'(bus.flush_end), exp_end);
      if (exp_valid == 1) begin
        check("fop_set", int'(bus.fop_set), m_fires % NUM_SETS);
        check("fop_way", int'(bus.fop_way), m_fires / NUM_SETS);
        check("fop_inval", int'(bus.fop_inval), INV);
      end else begin
        check("idle_op_fields", int'({bus.fop_set, bus.fop_way, bus.fop_inval}), 0);
      end

      f = (bus.fop_valid && bus.fop_ready) ? 1 : 0;
      d = bus.fop_done ? 1 : 0;
      if (f == 1) begin
        fire_total++;
        fire_cyc_q.push_back(cyc);
        fire_set_q.push_back(int'(bus.fop_set));
        fire_way_q.push_back(int'(bus.fop_way));
        if (bus.fop_inval) inval_total++;
      end
      if (bus.flush_end) begin
        end_total++;
        end_cyc_q.push_back(cyc);
      end
      if (bus.flush_busy) busy_total++;
      if (!reset) obs_pend = 0;
      else obs_pend = obs_pend + f - d;
      if (obs_pend > obs_pend_max) obs_pend_max = obs_pend;

      if (!reset) begin
        m_busy = 0; m_fires = 0; m_pend = 0; m_cd = 0;
      end else if (m_cd == 1) begin
        m_busy = 0; m_cd = 0;
      end else if (m_busy) begin
        if (m_fires == N && m_pend == 0 && bus.mreq_empty) m_cd = 1;
        if (exp_valid == 1 && bus.fop_ready) begin
          m_fires++;
          m_pend++;
        end
        if (bus.fop_done && m_pend > 0) m_pend--;
      end else if (bus.flush_begin) begin
        m_busy = 1; m_fires = 0; m_pend = 0;
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_begin();
    bus.flush_begin = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_begin = 1'b0;
  endtask

  task automatic wait_end(input int e0, input int budget);
    int n;
    n = 0;
    while (end_total == e0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("flush_end_within_budget", (end_total != e0) ? 1 : 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, b, rc, n, b0;
    reset = 1'b0;
    bus.flush_begin = 1'b0;
    bus.fop_ready = 1'b1;
    bus.mreq_empty = 1'b1;

    // Ideal flow
    goto(3);
    reset = 1'b1;
    goto(10);
    s = fire_total; e = end_total; b0 = busy_total;
    pulse_begin();
    wait_end(e, 40);
    goto(cyc + 3);
    check("ideal_fire_count", fire_total - s, 8);
    check("ideal_first_fire_cycle", q_at(fire_cyc_q, s), 11);
    check("ideal_last_fire_cycle", q_at(fire_cyc_q, s + 7), 18);
    check("ideal_fifth_op_set", q_at(fire_set_q, s + 4), 0);
    check("ideal_fifth_op_way", q_at(fire_way_q, s + 4), 1);
    check("ideal_end_cycle", q_at(end_cyc_q, e), 21);
    check("ideal_end_count", end_total - e, 1);
    check("ideal_busy_cycles", busy_total - b0, 11);
    check("ideal_inval_count", inval_total, 8 * INV);

    // Backpressure: retirements withheld for 20 cycles
    goto(cyc + 2);
    s = fire_total; e = end_total;
    hold_done = 1'b1;
    pulse_begin();
    goto(cyc + 20);
    check("bp_fires_while_held", fire_total - s, 2);
    check("bp_valid_low_while_held", int'(bus.fop_valid), 0);
    check("bp_pending_limit", (obs_pend_max <= MAXP) ? 1 : 0, 1);
    hold_done = 1'b0;
    wait_end(e, 60);
    check("bp_fire_count", fire_total - s, 8);
    check("bp_end_count", end_total - e, 1);

    // Drain gating on memory-request queue
    goto(cyc + 2);
    s = fire_total; e = end_total;
    bus.mreq_empty = 1'b0;
    b = cyc;
    pulse_begin();
    goto(b + 25);
    check("drain_fires_before_empty", fire_total - s, 8);
    check("drain_no_end_while_busy_mem", end_total - e, 0);
    rc = cyc;
    bus.mreq_empty = 1'b1;
    wait_end(e, 10);
    check("drain_end_cycle", q_at(end_cyc_q, e), rc + 1);

    // Reset in the middle of a walk
    goto(cyc + 2);
    s = fire_total; e = end_total;
    pulse_begin();
    n = 0;
    while (fire_total < s + 3 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_fires_before_reset", fire_total - s, 3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy_after_reset", int'(bus.flush_busy), 0);
    check("rst_valid_after_reset", int'(bus.fop_valid), 0);
    reset = 1'b1;
    goto(cyc + 10);
    check("rst_no_end", end_total - e, 0);
    check("rst_no_more_fires", fire_total - s, 3);
    s = fire_total;
    pulse_begin();
    wait_end(e, 40);
    check("rst_restart_set", q_at(fire_set_q, s), 0);
    check("rst_restart_way", q_at(fire_way_q, s), 0);
    check("rst_restart_fire_count", fire_total - s, 8);

    // Second request during a walk is ignored; ready also dips mid-walk
    goto(cyc + 2);
    s = fire_total; e = end_total;
    b = cyc;
    pulse_begin();
    goto(b + 4);
    pulse_begin();
    bus.fop_ready = 1'b0;
    goto(cyc + 3);
    bus.fop_ready = 1'b1;
    wait_end(e, 40);
    goto(cyc + 10);
    check("ign_fire_count", fire_total - s, 8);
    check("ign_end_count", end_total - e, 1);

    goto(cyc + 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
